// File: rtl/surf_cmd_deserializer.sv
// Serial trigger-command deserializer: decodes 37-bit single-wire frames into a LAB buffer
// number and 32-bit event ID, with a write strobe, stretched digitize requests and error counting.
module surf_cmd_deserializer #(
    parameter int unsigned DIG_LEN   = 4,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        cmd_i,
    output logic        event_id_wr_o,
    output logic [1:0]  event_id_buffer_o,
    output logic [31:0] event_id_o,
    output logic [3:0]  digitize_o,
    output logic        err_o,
    output logic [7:0]  err_count_o
);

    localparam logic [3:0] DIG_LEN_C = 4'(DIG_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUF    = 3'd1,
        ST_ID     = 3'd2,
        ST_PAR    = 3'd3,
        ST_STOP   = 3'd4,
        ST_RESYNC = 3'd5
    } state_t;

    state_t      state_r;
    logic        cmd_q_r;
    logic [5:0]  bit_cnt_r;
    logic [33:0] shift_r;
    logic        par_r;
    logic [3:0]  stretch_r     [4];
    logic [3:0]  stretch_nxt_s [4];
    logic        parity_ok_s;
    logic        accept_s;
    logic        reject_s;

    // Even parity over buffer number, event ID and the received parity bit.
    function automatic logic even_parity_ok(input logic [33:0] data, input logic par);
        return ~((^data) ^ par);
    endfunction

    // Accept/reject decision taken while the stop bit is visible in the STOP state.
    always_comb begin
        parity_ok_s = even_parity_ok(shift_r, par_r);
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        if (state_r == ST_STOP) begin
            if (cmd_q_r) begin
                reject_s = 1'b1;
            end else if (parity_ok_s || (PARITY_EN == 1'b0)) begin
                accept_s = 1'b1;
            end else begin
                reject_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Next value of each buffer's stretch counter: reload on accept, otherwise count down to zero.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            stretch_nxt_s[n] = stretch_r[n];
            if (accept_s && (shift_r[33:32] == 2'(n))) begin
                stretch_nxt_s[n] = DIG_LEN_C;
            end else if (stretch_r[n] != 4'd0) begin
                stretch_nxt_s[n] = stretch_r[n] - 4'd1;
            end else begin
                stretch_nxt_s[n] = stretch_r[n];
            end
        end
    end

    // Stretch counters and registered digitize requests.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            for (int n = 0; n < 4; n++) begin
                stretch_r[n] <= 4'd0;
            end
            digitize_o <= 4'd0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                stretch_r[n]  <= stretch_nxt_s[n];
                digitize_o[n] <= (stretch_nxt_s[n] != 4'd0);
            end
        end
    end

    // Input flop, frame FSM, shift register and registered result/error outputs.
    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            cmd_q_r           <= 1'b0;
            state_r           <= ST_IDLE;
            bit_cnt_r         <= 6'd0;
            shift_r           <= 34'd0;
            par_r             <= 1'b0;
            event_id_wr_o     <= 1'b0;
            event_id_buffer_o <= 2'd0;
            event_id_o        <= 32'd0;
            err_o             <= 1'b0;
            err_count_o       <= 8'd0;
        end else begin
            cmd_q_r       <= cmd_i;
            event_id_wr_o <= accept_s;
            err_o         <= reject_s;
            if (accept_s) begin
                event_id_buffer_o <= shift_r[33:32];
                event_id_o        <= shift_r[31:0];
            end
            if (reject_s && (err_count_o != 8'hFF)) begin
                err_count_o <= err_count_o + 8'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 6'd0;
                    if (cmd_q_r) begin
                        state_r <= ST_BUF;
                    end
                end
                ST_BUF: begin
                    shift_r <= {shift_r[32:0], cmd_q_r};
                    if (bit_cnt_r == 6'd1) begin
                        bit_cnt_r <= 6'd0;
                        state_r   <= ST_ID;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_ID: begin
                    shift_r <= {shift_r[32:0], cmd_q_r};
                    if (bit_cnt_r == 6'd31) begin
                        bit_cnt_r <= 6'd0;
                        state_r   <= ST_PAR;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_PAR: begin
                    par_r   <= cmd_q_r;
                    state_r <= ST_STOP;
                end
                // A high stop bit means we lost framing; wait for the line to drop before hunting again.
                ST_STOP: begin
                    state_r <= cmd_q_r ? ST_RESYNC : ST_IDLE;
                end
                ST_RESYNC: begin
                    if (!cmd_q_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_surf_cmd_deserializer.sv
// Directed self-checking bench for surf_cmd_deserializer; instance A uses defaults,
// instance B uses PARITY_EN=0 and DIG_LEN=15.
module tb_surf_cmd_deserializer;

    logic        clk = 1'b0;
    logic        rst_a, cmd_a, rst_b, cmd_b;
    logic        wr_a, err_a, wr_b, err_b;
    logic [1:0]  buf_a, buf_b;
    logic [31:0] id_a, id_b;
    logic [3:0]  dig_a, dig_b;
    logic [7:0]  errc_a, errc_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0]  dig_a_h [16384];
    logic [3:0]  dig_b_h [16384];
    int          wr_a_q[$];
    logic [33:0] wra_val_q[$];
    int          err_a_q[$];
    logic [7:0]  errc_at_err_q[$];
    int          wr_b_q[$];
    logic [33:0] wrb_val_q[$];
    int          err_b_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    surf_cmd_deserializer dut_a (
        .clk33_i(clk), .rst_i(rst_a), .cmd_i(cmd_a),
        .event_id_wr_o(wr_a), .event_id_buffer_o(buf_a), .event_id_o(id_a),
        .digitize_o(dig_a), .err_o(err_a), .err_count_o(errc_a)
    );

    surf_cmd_deserializer #(.DIG_LEN(15), .PARITY_EN(1'b0)) dut_b (
        .clk33_i(clk), .rst_i(rst_b), .cmd_i(cmd_b),
        .event_id_wr_o(wr_b), .event_id_buffer_o(buf_b), .event_id_o(id_b),
        .digitize_o(dig_b), .err_o(err_b), .err_count_o(errc_b)
    );

    // Log strobes and digitize history on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cyc < 16384) begin
            dig_a_h[cyc] <= dig_a;
            dig_b_h[cyc] <= dig_b;
        end
        if (wr_a === 1'b1) begin
            wr_a_q.push_back(cyc);
            wra_val_q.push_back({buf_a, id_a});
        end
        if (err_a === 1'b1) begin
            err_a_q.push_back(cyc);
            errc_at_err_q.push_back(errc_a);
        end
        if (wr_b === 1'b1) begin
            wr_b_q.push_back(cyc);
            wrb_val_q.push_back({buf_b, id_b});
        end
        if (err_b === 1'b1) err_b_q.push_back(cyc);
    end

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit sel_b, input logic b);
        if (sel_b) cmd_b = b;
        else       cmd_a = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel_b, input int n);
        for (int i = 0; i < n; i++) drive_bit(sel_b, 1'b0);
    endtask

    task automatic send_frame(input bit sel_b, input logic [1:0] bn, input logic [31:0] id,
                              input logic flip, input logic stop, output int e0);
        logic [36:0] fr;
        fr = {1'b1, bn, id, (^{bn, id}) ^ flip, stop};
        e0 = 0;
        for (int i = 36; i >= 0; i--) begin
            drive_bit(sel_b, fr[i]);
            if (i == 36) e0 = cyc;
        end
    endtask

    task automatic clr_logs();
        wr_a_q.delete(); wra_val_q.delete(); err_a_q.delete(); errc_at_err_q.delete();
        wr_b_q.delete(); wrb_val_q.delete(); err_b_q.delete();
    endtask

    task automatic chk_all_zero_a(input string tag);
        chk_val({tag, "_wr"},   {63'd0, wr_a},   64'd0);
        chk_val({tag, "_buf"},  {62'd0, buf_a},  64'd0);
        chk_val({tag, "_id"},   {32'd0, id_a},   64'd0);
        chk_val({tag, "_dig"},  {60'd0, dig_a},  64'd0);
        chk_val({tag, "_err"},  {63'd0, err_a},  64'd0);
        chk_val({tag, "_errc"}, {56'd0, errc_a}, 64'd0);
    endtask

    initial begin
        int e0, e1;
        logic [19:0] part;
        rst_a = 1'b1; rst_b = 1'b1; cmd_a = 1'b0; cmd_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero_a("reset");
        rst_a = 1'b0; rst_b = 1'b0;
        idle(1'b0, 2);

        // Single good frame, buf=2 id=1
        clr_logs();
        send_frame(1'b0, 2'd2, 32'h0000_0001, 1'b0, 1'b0, e0);
        idle(1'b0, 8);
        chk_val("t1_wr_cnt", 64'(wr_a_q.size()), 64'd1);
        if (wr_a_q.size() >= 1) begin
            chk_val("t1_wr_cyc", 64'(wr_a_q[0]), 64'(e0 + 37));
            chk_val("t1_val", {30'd0, wra_val_q[0]}, {30'd0, 2'd2, 32'h0000_0001});
        end
        chk_val("t1_err_cnt", 64'(err_a_q.size()), 64'd0);
        chk_val("t1_dig_pre", {60'd0, dig_a_h[e0 + 36]}, 64'd0);
        for (int k = 37; k <= 40; k++) chk_val("t1_dig_on", {60'd0, dig_a_h[e0 + k]}, 64'b0100);
        chk_val("t1_dig_off", {60'd0, dig_a_h[e0 + 41]}, 64'd0);

        // Back-to-back frames
        clr_logs();
        send_frame(1'b0, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, e0);
        send_frame(1'b0, 2'd3, 32'h1234_5678, 1'b0, 1'b0, e1);
        idle(1'b0, 8);
        chk_val("t2_wr_cnt", 64'(wr_a_q.size()), 64'd2);
        if (wr_a_q.size() >= 2) begin
            chk_val("t2_wr0_cyc", 64'(wr_a_q[0]), 64'(e0 + 37));
            chk_val("t2_wr1_cyc", 64'(wr_a_q[1]), 64'(e0 + 74));
            chk_val("t2_val0", {30'd0, wra_val_q[0]}, {30'd0, 2'd0, 32'hDEAD_BEEF});
            chk_val("t2_val1", {30'd0, wra_val_q[1]}, {30'd0, 2'd3, 32'h1234_5678});
        end
        for (int k = 37; k <= 40; k++) chk_val("t2_dig0", {60'd0, dig_a_h[e0 + k]}, 64'b0001);
        chk_val("t2_dig_gap", {60'd0, dig_a_h[e0 + 41]}, 64'd0);
        for (int k = 74; k <= 77; k++) chk_val("t2_dig3", {60'd0, dig_a_h[e0 + k]}, 64'b1000);
        chk_val("t2_dig_end", {60'd0, dig_a_h[e0 + 78]}, 64'd0);

        // Bad parity: rejected on A, accepted on B (parity ignored)
        clr_logs();
        send_frame(1'b0, 2'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, e0);
        idle(1'b0, 8);
        chk_val("t3_wr_cnt", 64'(wr_a_q.size()), 64'd0);
        chk_val("t3_err_cnt", 64'(err_a_q.size()), 64'd1);
        if (err_a_q.size() >= 1) begin
            chk_val("t3_err_cyc", 64'(err_a_q[0]), 64'(e0 + 37));
            chk_val("t3_errc_same", {56'd0, errc_at_err_q[0]}, 64'd1);
        end
        chk_val("t3_errc", {56'd0, errc_a}, 64'd1);
        chk_val("t3_id_held", {32'd0, id_a}, {32'd0, 32'h1234_5678});
        chk_val("t3_buf_held", {62'd0, buf_a}, 64'd3);
        chk_val("t3_dig", {60'd0, dig_a_h[e0 + 37]}, 64'd0);
        send_frame(1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, e0);
        idle(1'b1, 8);
        chk_val("t3b_wr_cnt", 64'(wr_b_q.size()), 64'd1);
        if (wr_b_q.size() >= 1) begin
            chk_val("t3b_wr_cyc", 64'(wr_b_q[0]), 64'(e0 + 37));
            chk_val("t3b_val", {30'd0, wrb_val_q[0]}, {30'd0, 2'd0, 32'hFFFF_FFFF});
        end
        chk_val("t3b_err_cnt", 64'(err_b_q.size()), 64'd0);
        chk_val("t3b_dig", {60'd0, dig_b_h[e0 + 37]}, 64'b0001);

        // Stop bit high for 3 cycles, then a good frame after resync
        clr_logs();
        send_frame(1'b0, 2'd1, 32'hCAFE_0001, 1'b0, 1'b1, e0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        idle(1'b0, 3);
        send_frame(1'b0, 2'd2, 32'h0BAD_F00D, 1'b0, 1'b0, e1);
        idle(1'b0, 8);
        chk_val("t4_err_cnt", 64'(err_a_q.size()), 64'd1);
        if (err_a_q.size() >= 1) chk_val("t4_err_cyc", 64'(err_a_q[0]), 64'(e0 + 37));
        chk_val("t4_errc", {56'd0, errc_a}, 64'd2);
        chk_val("t4_wr_cnt", 64'(wr_a_q.size()), 64'd1);
        if (wr_a_q.size() >= 1) begin
            chk_val("t4_wr_cyc", 64'(wr_a_q[0]), 64'(e1 + 37));
            chk_val("t4_val", {30'd0, wra_val_q[0]}, {30'd0, 2'd2, 32'h0BAD_F00D});
        end

        // Reset at the 20th frame bit, then a good frame
        clr_logs();
        part = {1'b1, 2'd3, 17'h10000};
        for (int i = 19; i >= 0; i--) drive_bit(1'b0, part[i]);
        rst_a = 1'b1;
        for (int r = 0; r < 3; r++) begin
            drive_bit(1'b0, 1'b0);
            chk_all_zero_a("t5_rst");
        end
        rst_a = 1'b0;
        idle(1'b0, 3);
        send_frame(1'b0, 2'd1, 32'hA5A5_0F0F, 1'b0, 1'b0, e1);
        idle(1'b0, 8);
        chk_val("t5_wr_cnt", 64'(wr_a_q.size()), 64'd1);
        if (wr_a_q.size() >= 1) begin
            chk_val("t5_wr_cyc", 64'(wr_a_q[0]), 64'(e1 + 37));
            chk_val("t5_val", {30'd0, wra_val_q[0]}, {30'd0, 2'd1, 32'hA5A5_0F0F});
        end
        chk_val("t5_err_cnt", 64'(err_a_q.size()), 64'd0);
        chk_val("t5_errc", {56'd0, errc_a}, 64'd0);
        chk_val("t5_dig", {60'd0, dig_a_h[e1 + 37]}, 64'b0010);

        // 300 bad-parity frames: error counter saturates
        clr_logs();
        for (int k = 0; k < 300; k++) send_frame(1'b0, 2'd1, 32'(k), 1'b1, 1'b0, e0);
        idle(1'b0, 8);
        chk_val("t6_err_cnt", 64'(err_a_q.size()), 64'd300);
        chk_val("t6_wr_cnt", 64'(wr_a_q.size()), 64'd0);
        chk_val("t6_errc_sat", {56'd0, errc_a}, 64'd255);
        if (errc_at_err_q.size() >= 256) begin
            chk_val("t6_errc_253", {56'd0, errc_at_err_q[253]}, 64'd254);
            chk_val("t6_errc_254", {56'd0, errc_at_err_q[254]}, 64'd255);
            chk_val("t6_errc_255", {56'd0, errc_at_err_q[255]}, 64'd255);
        end

        // Instance B, DIG_LEN=15: two accepts to buf 1, 37 cycles apart
        clr_logs();
        send_frame(1'b1, 2'd1, 32'h0000_0011, 1'b0, 1'b0, e0);
        send_frame(1'b1, 2'd1, 32'h0000_0022, 1'b0, 1'b0, e1);
        idle(1'b1, 20);
        chk_val("t7_wr_cnt", 64'(wr_b_q.size()), 64'd2);
        if (wr_b_q.size() >= 2) chk_val("t7_wr1_cyc", 64'(wr_b_q[1]), 64'(e0 + 74));
        chk_val("t7_dig_rise1", {60'd0, dig_b_h[e0 + 37]}, 64'b0010);
        chk_val("t7_dig_last1", {60'd0, dig_b_h[e0 + 51]}, 64'b0010);
        chk_val("t7_dig_fall1", {60'd0, dig_b_h[e0 + 52]}, 64'd0);
        chk_val("t7_dig_rise2", {60'd0, dig_b_h[e0 + 74]}, 64'b0010);
        chk_val("t7_dig_last2", {60'd0, dig_b_h[e0 + 88]}, 64'b0010);
        chk_val("t7_dig_fall2", {60'd0, dig_b_h[e0 + 89]}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
